// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves load-use,
// redirect, fetch-wait, backend-wait and halt into per-stage controls,
// parks a redirect that lands during a fetch wait, and counts stall and
// redirect cycles with saturating counters.
module pipe_hazard_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_redirect_i,
    input  logic [DATA_WIDTH-1:0] ex_target_i,
    input  logic                  imem_wait_i,
    input  logic                  dmem_wait_i,
    input  logic                  wb_halt_i,
    output logic                  pc_stall_o,
    output logic                  pc_redirect_o,
    output logic [DATA_WIDTH-1:0] pc_target_o,
    output logic                  ifid_stall_o,
    output logic                  ifid_flush_o,
    output logic                  idex_stall_o,
    output logic                  idex_flush_o,
    output logic                  exmem_stall_o,
    output logic                  halted_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  redir_cnt_o
);

    typedef enum logic [1:0] {RUN, PEND, HALT} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                state, state_nxt;
    logic                  pend_valid, pend_valid_nxt;
    logic [DATA_WIDTH-1:0] pend_pc, pend_pc_nxt;
    logic                  bs, lu, rd_new;

    // Backend wait freezes EX, so a redirect seen under it is not yet real.
    assign bs     = dmem_wait_i;
    assign lu     = ex_is_load_i && (ex_rd_i != '0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
    assign rd_new = ex_redirect_i && !bs;

    // State, parked redirect target and its valid flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= RUN;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            state      <= state_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
        end
    end

    // Stage controls and next state; backend wait outranks redirect, which outranks load-use.
    always_comb begin
        pc_stall_o     = 1'b0;
        pc_redirect_o  = 1'b0;
        pc_target_o    = pend_valid ? pend_pc : ex_target_i;
        ifid_stall_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_stall_o   = 1'b0;
        idex_flush_o   = 1'b0;
        exmem_stall_o  = 1'b0;
        halted_o       = 1'b0;
        state_nxt      = state;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        case (state)
            RUN: begin
                if (bs) begin
                    pc_stall_o    = 1'b1;
                    ifid_stall_o  = 1'b1;
                    idex_stall_o  = 1'b1;
                    exmem_stall_o = 1'b1;
                end else if (rd_new) begin
                    ifid_flush_o = 1'b1;
                    idex_flush_o = 1'b1;
                    if (imem_wait_i) begin
                        // Fetch is busy: park the target until it can be taken.
                        pc_stall_o     = 1'b1;
                        pend_pc_nxt    = ex_target_i;
                        pend_valid_nxt = 1'b1;
                        state_nxt      = PEND;
                    end else begin
                        pc_redirect_o = 1'b1;
                        pc_target_o   = ex_target_i;
                    end
                end else if (lu) begin
                    // Hold the consumer in ID and send a bubble into EX.
                    pc_stall_o   = 1'b1;
                    ifid_stall_o = 1'b1;
                    idex_flush_o = 1'b1;
                end else if (imem_wait_i) begin
                    pc_stall_o   = 1'b1;
                    ifid_flush_o = 1'b1;
                end
            end
            PEND: begin
                if (bs) begin
                    pc_stall_o    = 1'b1;
                    ifid_stall_o  = 1'b1;
                    idex_stall_o  = 1'b1;
                    exmem_stall_o = 1'b1;
                end else begin
                    ifid_flush_o = 1'b1;
                    idex_flush_o = rd_new;
                    if (!imem_wait_i) begin
                        // A same-cycle redirect is younger than the parked one.
                        pc_redirect_o  = 1'b1;
                        if (rd_new) pc_target_o = ex_target_i;
                        pend_valid_nxt = 1'b0;
                        state_nxt      = RUN;
                    end else begin
                        pc_stall_o = 1'b1;
                        if (rd_new) pend_pc_nxt = ex_target_i;
                    end
                end
            end
            HALT: begin
                halted_o      = 1'b1;
                pc_stall_o    = 1'b1;
                ifid_stall_o  = 1'b1;
                idex_stall_o  = 1'b1;
                exmem_stall_o = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
        // Retiring ebreak wins from any state and drops a parked redirect.
        if (wb_halt_i && !bs) begin
            state_nxt      = HALT;
            pend_valid_nxt = 1'b0;
        end
    end

    // Saturating performance counters, frozen once halted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
            redir_cnt_o <= '0;
        end else if (state != HALT) begin
            if (pc_stall_o && (stall_cnt_o != '1))    stall_cnt_o <= stall_cnt_o + CNT_ONE;
            if (pc_redirect_o && (redir_cnt_o != '1)) redir_cnt_o <= redir_cnt_o + CNT_ONE;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage rv64i pipeline.
- Drives stall_i/flush_i of the IF/ID, ID/EX and EX/MEM stage registers and the PC-update enable.
- Inputs: load-use hazard, EX-stage branch/jump redirect, instruction- and data-memory wait, WB-stage halt (ebreak).
- Holds a redirect that arrives during an instruction-fetch wait, and keeps saturating stall/redirect performance counters.

Parameters:
DATA_WIDTH, 64, PC/redirect target width
REG_ADDR_W, 5, register index width
CNT_WIDTH, 32, performance counter width

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
id_rs1_i  input  REG_ADDR_W  rs1 of instruction in ID
id_rs2_i  input  REG_ADDR_W  rs2 of instruction in ID
id_use_rs1_i  input  1  ID instruction reads rs1
id_use_rs2_i  input  1  ID instruction reads rs2
ex_rd_i  input  REG_ADDR_W  rd of instruction in EX
ex_is_load_i  input  1  EX instruction is a load writing rd
ex_redirect_i  input  1  EX resolved taken branch/jump (mispredict)
ex_target_i  input  DATA_WIDTH  redirect target PC
imem_wait_i  input  1  fetch not complete this cycle
dmem_wait_i  input  1  data memory access not complete (backend stall)
wb_halt_i  input  1  ebreak retiring in WB
pc_stall_o  output  1  hold PC register
pc_redirect_o  output  1  load PC with pc_target_o this cycle
pc_target_o  output  DATA_WIDTH  redirect target
ifid_stall_o  output  1  IF/ID stall_i
ifid_flush_o  output  1  IF/ID flush_i
idex_stall_o  output  1  ID/EX stall_i
idex_flush_o  output  1  ID/EX flush_i (bubble insert)
exmem_stall_o  output  1  EX/MEM stall_i
halted_o  output  1  core halted
stall_cnt_o  output  CNT_WIDTH  cycles with pc_stall_o=1
redir_cnt_o  output  CNT_WIDTH  redirects applied

Behaviour:
- Reset (async on rst_n_i low): state=RUN, pend_valid=0, pend_pc=0, both counters=0, halted_o=0. Release takes effect on the next rising edge.
- All stage-control outputs are combinational from state, pend registers and inputs. State, pending redirect and counters update on the rising edge.
- Definitions:
  - bs = dmem_wait_i.
  - lu = ex_is_load_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
  - rd_new = ex_redirect_i & !bs.
  - A redirect ex_redirect_i is ignored while bs=1; EX is frozen and reasserts it.
- FSM states: RUN, PEND (redirect captured, fetch busy), HALT.
- RUN:
  - rd_new & !imem_wait_i: pc_redirect_o=1, pc_target_o=ex_target_i, ifid_flush_o=1, idex_flush_o=1; stay RUN.
  - rd_new & imem_wait_i: pend_pc<=ex_target_i, pend_valid<=1, ifid_flush_o=1, idex_flush_o=1, pc_stall_o=1; go PEND.
  - Redirect beats load-use: lu is suppressed (ifid_stall_o=0) whenever rd_new=1.
  - lu & !rd_new & !bs: pc_stall_o=1, ifid_stall_o=1, idex_flush_o=1 (one bubble per lu cycle).
  - imem_wait_i & !rd_new & !bs: pc_stall_o=1, ifid_flush_o=1 (fetch bubble into ID).
  - bs=1: pc_stall_o=ifid_stall_o=idex_stall_o=exmem_stall_o=1; every flush is 0.
- PEND:
  - ifid_flush_o=1 each cycle unless bs. pc_target_o=pend_pc.
  - Exit when imem_wait_i=0 & !bs: pc_redirect_o=1, pend_valid<=0; go RUN.
  - Until exit, pc_stall_o=1.
  - A new rd_new in PEND overwrites pend_pc (latest wins) and also flushes ID/EX.
  - If imem_wait_i=0 and rd_new occur in the same cycle, apply ex_target_i directly and clear pend_valid.
- HALT:
  - Entered when wb_halt_i=1 & !bs, from any state; a pending redirect is discarded.
  - halted_o=1; all stall outputs=1, all flush/redirect outputs=0.
  - Exit only by reset.
- pc_stall_o is 0 in any cycle where pc_redirect_o=1.
- When pc_redirect_o=0, pc_target_o = pend_pc in PEND, else ex_target_i.
- Counters: stall_cnt_o +1 per cycle with pc_stall_o=1; redir_cnt_o +1 per cycle with pc_redirect_o=1. Both saturate at all-ones and freeze in HALT.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, use_rs1=1 for 1 cycle -> pc_stall=1, ifid_stall=1, idex_flush=1, stall_cnt 0->1. With ex_rd=0 instead -> no stall.
- Redirect, fetch ready: ex_redirect=1, target=0x80000040, imem_wait=0 -> same cycle pc_redirect=1, pc_target=0x80000040, ifid_flush=idex_flush=1; redir_cnt=1.
- Redirect during fetch wait: imem_wait=1 for 3 cycles with ex_redirect at cycle 0 (target 0x80000100) -> PEND for 3 cycles with ifid_flush=1. When imem_wait drops: pc_redirect=1, target=0x80000100; back to RUN.
- Backend stall priority: dmem_wait=1 together with ex_redirect=1 and lu=1 -> all four stall outputs=1, no flush/redirect. dmem_wait drops -> redirect applied, lu suppressed.
- Halt and reset: wb_halt=1 -> halted_o=1 next cycle, stalls held, counters frozen. Assert rst_n_i=0 asynchronously mid-cycle -> outputs and counters return to reset values immediately.
- Saturation: preload stall_cnt to all-ones via a long stall -> count holds at 0xFFFFFFFF.
